// File: rtl/reaction_game_sm.sv
// Rotating-LED reaction game sub-FSM; runs while MASTER_STATE == MY_STATE, reports hits on STATUS_OUT.
// Optional macro SPEEDUP_EN shortens the LED step period as the hit count climbs.
module reaction_game_sm #(
  parameter logic [1:0] MY_STATE    = 2'b11,
  parameter int         TICK_DIV    = 25_000_000,
  parameter int         TARGET_HITS = 15
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [1:0] MASTER_STATE,
  input  logic       BTNC,
  output logic [7:0] LED_OUT,
  output logic [3:0] STATUS_OUT
);

  localparam logic [3:0] TARGET = 4'(TARGET_HITS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  state_t      state_next;
  logic [25:0] tick;
  logic [25:0] tick_next;
  logic [25:0] tick_last;
  logic [3:0]  hits;
  logic [3:0]  hits_next;
  logic [3:0]  hits_inc;
  logic [7:0]  led_next;
  logic [3:0]  status_next;
  logic        active;
  logic        sync1;
  logic        sync2;
  logic        sync3;
  logic        press;

  assign active   = (MASTER_STATE == MY_STATE);
  assign hits_inc = hits + 4'd1;

  // The press pulse is registered, so the FSM acts on it at the 4th edge after BTNC rises.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
      press <= 1'b0;
    end else begin
      sync1 <= BTNC;
      sync2 <= sync1;
      sync3 <= sync2;
      press <= sync2 & ~sync3;
    end
  end

`ifdef SPEEDUP_EN
  localparam logic [25:0] TICK_FULL = 26'(TICK_DIV);
  logic [25:0] period;

  // Periods that shift down to 0 or 1 degenerate to a step every cycle.
  always_comb begin
    period    = TICK_FULL >> hits[3:2];
    tick_last = (period <= 26'd1) ? 26'd0 : period - 26'd1;
  end
`else
  localparam logic [25:0] TICK_LAST = 26'(TICK_DIV - 1);

  assign tick_last = TICK_LAST;
`endif

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state      <= IDLE;
      tick       <= 26'd0;
      hits       <= 4'd0;
      LED_OUT    <= 8'h00;
      STATUS_OUT <= 4'h0;
    end else begin
      state      <= state_next;
      tick       <= tick_next;
      hits       <= hits_next;
      LED_OUT    <= led_next;
      STATUS_OUT <= status_next;
    end
  end

  always_comb begin
    state_next = state;
    if (!active) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    state_next = RUN;
        RUN:     if (press && LED_OUT[7] && hits_inc == TARGET) state_next = DONE;
        DONE:    state_next = DONE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Hit/miss is judged on the current LED_OUT, so a same-cycle rotate never affects the verdict.
  always_comb begin
    tick_next   = tick;
    hits_next   = hits;
    led_next    = LED_OUT;
    status_next = STATUS_OUT;
    if (!active) begin
      tick_next   = 26'd0;
      hits_next   = 4'd0;
      led_next    = 8'h00;
      status_next = 4'h0;
    end else begin
      case (state)
        IDLE: begin
          tick_next   = 26'd0;
          hits_next   = 4'd0;
          led_next    = 8'h01;
          status_next = 4'h0;
        end
        RUN: begin
          if (tick >= tick_last) begin
            tick_next = 26'd0;
            led_next  = {LED_OUT[6:0], LED_OUT[7]};
          end else begin
            tick_next = tick + 26'd1;
          end
          if (press) begin
            if (LED_OUT[7]) begin
              hits_next = hits_inc;
              if (hits_inc == TARGET) begin
                led_next    = 8'hFF;
                status_next = 4'hF;
              end else begin
                status_next = hits_inc;
              end
            end else begin
              hits_next   = 4'd0;
              status_next = 4'h0;
            end
          end
`ifdef SPEEDUP_EN
          if (hits_next[3:2] != hits[3:2]) tick_next = 26'd0;
`endif
        end
        DONE: begin
          led_next    = 8'hFF;
          status_next = 4'hF;
        end
        default: begin
          tick_next   = 26'd0;
          hits_next   = 4'd0;
          led_next    = 8'h00;
          status_next = 4'h0;
        end
      endcase
    end
  end

endmodule
